// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer: one neuron at a time, CHUNK MAC lanes per cycle,
// results leave on a valid/ready stream with optional shift, saturation and ReLU.
module fc_layer_stream #(
   parameter int IN_DIM  = 1568,
   parameter int OUT_DIM = 128,
   parameter int CHUNK   = 8,
   parameter int ACT_W   = 32,
   parameter int W_W     = 8,
   parameter int ACC_W   = 48,
   parameter int OUT_W   = 32,
   parameter int SHIFT   = 0,
   parameter int RELU_EN = 1,
   localparam int NCHUNK = (IN_DIM + CHUNK - 1) / CHUNK,
   localparam int AW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1,
   localparam int WAW    = (OUT_DIM * NCHUNK > 1) ? $clog2(OUT_DIM * NCHUNK) : 1,
   localparam int NW     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic [AW-1:0]          act_addr,
   input  logic [CHUNK*ACT_W-1:0] act_rdata,
   output logic [WAW-1:0]         w_addr,
   input  logic [CHUNK*W_W-1:0]   w_rdata,
   output logic [NW-1:0]          bias_addr,
   input  logic [31:0]            bias_rdata,
   output logic                   rd_en,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NW-1:0]          out_idx,
   output logic [OUT_W-1:0]       out_data
);

   typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, EMIT, FINISH, WAIT_LOW} state_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   state_t                   state;
   logic [NW-1:0]            n;
   logic [WAW-1:0]           w_base;
   logic [AW-1:0]            data_c;
   logic                     first;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  chunk_sum;
   logic signed [ACC_W-1:0]  acc_sum;
   logic signed [ACC_W-1:0]  a_ext;
   logic signed [ACC_W-1:0]  w_ext;

   // data_c names the chunk whose read data is on the bus this cycle; lanes past IN_DIM are dropped
   always_comb begin
      chunk_sum = '0;
      a_ext     = '0;
      w_ext     = '0;
      for (int i = 0; i < CHUNK; i++) begin
         a_ext = {{(ACC_W-ACT_W){act_rdata[i*ACT_W+ACT_W-1]}}, act_rdata[i*ACT_W +: ACT_W]};
         w_ext = {{(ACC_W-W_W){w_rdata[i*W_W+W_W-1]}}, w_rdata[i*W_W +: W_W]};
         if (int'(data_c) * CHUNK + i < IN_DIM)
            chunk_sum = chunk_sum + a_ext * w_ext;
      end
      acc_sum = acc + chunk_sum;
   end

   function automatic logic [OUT_W-1:0] post_proc(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] t;
      t = a >>> SHIFT;
      if (t > SAT_MAX)
         t = SAT_MAX;
      else if (t < SAT_MIN)
         t = SAT_MIN;
      if (RELU_EN != 0 && t[ACC_W-1])
         t = '0;
      return t[OUT_W-1:0];
   endfunction

   // act_addr doubles as the chunk counter c; w_addr walks from w_base = n*NCHUNK
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         n         <= '0;
         w_base    <= '0;
         data_c    <= '0;
         first     <= 1'b0;
         acc       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         act_addr  <= '0;
         w_addr    <= '0;
         bias_addr <= '0;
         rd_en     <= 1'b0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_data  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= LOAD;
                  busy      <= 1'b1;
                  rd_en     <= 1'b1;
                  n         <= '0;
                  bias_addr <= '0;
                  w_base    <= '0;
               end
            end
            LOAD: begin
               state    <= MAC;
               act_addr <= '0;
               w_addr   <= w_base;
               first    <= 1'b1;
            end
            MAC: begin
               data_c <= act_addr;
               first  <= 1'b0;
               acc    <= first ? {{(ACC_W-32){bias_rdata[31]}}, bias_rdata} : acc_sum;
               if (act_addr == AW'(NCHUNK - 1)) begin
                  state <= DRAIN;
                  rd_en <= 1'b0;
               end else begin
                  act_addr <= act_addr + AW'(1);
                  w_addr   <= w_addr + WAW'(1);
               end
            end
            DRAIN: begin
               acc       <= acc_sum;
               state     <= EMIT;
               out_valid <= 1'b1;
               out_idx   <= n;
               out_data  <= post_proc(acc_sum);
            end
            EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (n == NW'(OUT_DIM - 1)) begin
                     state <= FINISH;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state     <= LOAD;
                     n         <= n + NW'(1);
                     bias_addr <= n + NW'(1);
                     w_base    <= w_base + WAW'(NCHUNK);
                     rd_en     <= 1'b1;
                  end
               end
            end
            FINISH:   state <= WAIT_LOW;
            WAIT_LOW: if (!start) state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_layer_stream.sv
// Directed bench for fc_layer_stream: three small instances (ReLU, 16-bit no-ReLU,
// shift-by-2 no-ReLU) share one memory image and are exercised one at a time.
module tb_fc_layer_stream;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic out_ready = 1'b1;
   int   sel = 0;
   int   tests = 0;
   int   failed = 0;

   always #5 clk = ~clk;

   logic [31:0] act_mem [12];
   logic [7:0]  w_mem [3][12];
   logic [31:0] bias_mem [3];

   logic         a_start, b_start, c_start;
   logic         a_busy, b_busy, c_busy, a_done, b_done, c_done;
   logic [1:0]   a_act_addr, b_act_addr, c_act_addr;
   logic [3:0]   a_w_addr, b_w_addr, c_w_addr;
   logic [1:0]   a_bias_addr, b_bias_addr, c_bias_addr;
   logic         a_rd_en, b_rd_en, c_rd_en;
   logic [127:0] a_act_rdata, b_act_rdata, c_act_rdata;
   logic [31:0]  a_w_rdata, b_w_rdata, c_w_rdata;
   logic [31:0]  a_bias_rdata, b_bias_rdata, c_bias_rdata;
   logic         a_out_valid, b_out_valid, c_out_valid;
   logic [1:0]   a_out_idx, b_out_idx, c_out_idx;
   logic [31:0]  a_out_data, c_out_data;
   logic [15:0]  b_out_data;

   assign a_start = start && (sel == 0);
   assign b_start = start && (sel == 1);
   assign c_start = start && (sel == 2);

   fc_layer_stream #(.IN_DIM(10), .OUT_DIM(3), .CHUNK(4), .OUT_W(32), .SHIFT(0), .RELU_EN(1)) dut_a (
      .clk(clk), .reset(reset), .start(a_start), .busy(a_busy), .done(a_done),
      .act_addr(a_act_addr), .act_rdata(a_act_rdata), .w_addr(a_w_addr), .w_rdata(a_w_rdata),
      .bias_addr(a_bias_addr), .bias_rdata(a_bias_rdata), .rd_en(a_rd_en),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_idx(a_out_idx), .out_data(a_out_data));

   fc_layer_stream #(.IN_DIM(10), .OUT_DIM(3), .CHUNK(4), .OUT_W(16), .SHIFT(0), .RELU_EN(0)) dut_b (
      .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
      .act_addr(b_act_addr), .act_rdata(b_act_rdata), .w_addr(b_w_addr), .w_rdata(b_w_rdata),
      .bias_addr(b_bias_addr), .bias_rdata(b_bias_rdata), .rd_en(b_rd_en),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_idx(b_out_idx), .out_data(b_out_data));

   fc_layer_stream #(.IN_DIM(10), .OUT_DIM(3), .CHUNK(4), .OUT_W(32), .SHIFT(2), .RELU_EN(0)) dut_c (
      .clk(clk), .reset(reset), .start(c_start), .busy(c_busy), .done(c_done),
      .act_addr(c_act_addr), .act_rdata(c_act_rdata), .w_addr(c_w_addr), .w_rdata(c_w_rdata),
      .bias_addr(c_bias_addr), .bias_rdata(c_bias_rdata), .rd_en(c_rd_en),
      .out_valid(c_out_valid), .out_ready(out_ready), .out_idx(c_out_idx), .out_data(c_out_data));

   function automatic logic [127:0] pack_act(input logic [1:0] c);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 4; i++)
         if (int'(c) * 4 + i < 12) r[i*32 +: 32] = act_mem[int'(c) * 4 + i];
      return r;
   endfunction

   function automatic logic [31:0] pack_w(input logic [3:0] a);
      logic [31:0] r;
      int nn, cc;
      r  = '0;
      nn = int'(a) / 3;
      cc = int'(a) % 3;
      for (int i = 0; i < 4; i++)
         if (nn < 3) r[i*8 +: 8] = w_mem[nn][cc * 4 + i];
      return r;
   endfunction

   function automatic logic [31:0] bias_of(input logic [1:0] a);
      return (int'(a) < 3) ? bias_mem[int'(a)] : 32'd0;
   endfunction

   // one-cycle-latency read ports for each instance
   always @(posedge clk) begin
      a_act_rdata <= pack_act(a_act_addr); a_w_rdata <= pack_w(a_w_addr); a_bias_rdata <= bias_of(a_bias_addr);
      b_act_rdata <= pack_act(b_act_addr); b_w_rdata <= pack_w(b_w_addr); b_bias_rdata <= bias_of(b_bias_addr);
      c_act_rdata <= pack_act(c_act_addr); c_w_rdata <= pack_w(c_w_addr); c_bias_rdata <= bias_of(c_bias_addr);
   end

   logic        m_valid, m_done, m_busy;
   logic [1:0]  m_idx;
   logic [31:0] m_data;

   always_comb begin
      m_valid = a_out_valid; m_idx = a_out_idx; m_data = a_out_data; m_done = a_done; m_busy = a_busy;
      if (sel == 1) begin
         m_valid = b_out_valid; m_idx = b_out_idx; m_data = {{16{b_out_data[15]}}, b_out_data};
         m_done = b_done; m_busy = b_busy;
      end else if (sel == 2) begin
         m_valid = c_out_valid; m_idx = c_out_idx; m_data = c_out_data; m_done = c_done; m_busy = c_busy;
      end
   end

   logic [31:0] cap_data [8];
   logic [1:0]  cap_idx [8];
   int          cap_n;
   int          done_busy;

   // starts a pass on the selected instance, captures handshakes, optionally stalls one neuron 5 cycles
   task automatic run_pass(input int stall_idx, input bit hold_start, output int cycles);
      int k, stall_left;
      bit stalled;
      logic [31:0] s_data;
      logic [1:0]  s_idx;
      cap_n = 0; cycles = -1; k = 0; stall_left = 0; stalled = 1'b0;
      s_data = '0; s_idx = '0; done_busy = -1;
      for (int i = 0; i < 8; i++) begin cap_data[i] = 32'hDEAD_BEEF; cap_idx[i] = 2'd3; end
      @(posedge clk); #1;
      start = 1'b1; out_ready = 1'b1;
      while (k < 200 && cycles < 0) begin
         @(negedge clk);
         k++;
         if (k >= 2 && !hold_start) start = 1'b0;
         if (!stalled && m_valid && int'(m_idx) == stall_idx) begin
            stalled = 1'b1; stall_left = 4; s_data = m_data; s_idx = m_idx; out_ready = 1'b0;
         end else if (stall_left > 0) begin
            stall_left--;
            out_ready = 1'b0;
            tests++;
            if (m_valid !== 1'b1 || m_idx !== s_idx || m_data !== s_data) begin
               failed++;
               $display("[TB] FAIL stall_stable: got v=%b idx=%0d data=%0d, want v=1 idx=%0d data=%0d",
                        m_valid, m_idx, $signed(m_data), s_idx, $signed(s_data));
            end
         end else begin
            out_ready = 1'b1;
         end
         if (m_valid && out_ready && cap_n < 8) begin
            cap_data[cap_n] = m_data; cap_idx[cap_n] = m_idx; cap_n++;
         end
         if (m_done) begin cycles = k; done_busy = int'(m_busy); end
      end
      out_ready = 1'b1;
      if (cycles < 0) begin
         tests++; failed++;
         $display("[TB] FAIL pass_timeout: got no done within 200 cycles, want done");
      end
   endtask

   task automatic set_mem_basic();
      for (int k = 0; k < 12; k++) begin
         act_mem[k] = (k < 10) ? 32'(k + 1) : 32'd0;
         for (int n = 0; n < 3; n++) w_mem[n][k] = (k < 10) ? 8'd1 : 8'd0;
      end
      for (int n = 0; n < 3; n++) bias_mem[n] = 32'd0;
   endtask

   task automatic applyStimulus_idle(input int cycles_n);
      repeat (cycles_n) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if ({a_busy, a_done, a_rd_en, a_out_valid, a_act_addr, a_w_addr, a_bias_addr, a_out_idx, a_out_data, b_out_data} !== '0) begin
         failed++;
         $display("[TB] FAIL reset_outputs: got busy=%b done=%b rd_en=%b valid=%b data=%0d, want all 0",
                  a_busy, a_done, a_rd_en, a_out_valid, a_out_data);
      end
      reset = 1'b0;
      applyStimulus_idle(3);
      tests++;
      if (a_busy !== 1'b0 || a_rd_en !== 1'b0) begin
         failed++;
         $display("[TB] FAIL idle_after_reset: got busy=%b rd_en=%b, want 0 0", a_busy, a_rd_en);
      end
   endtask

   task automatic test_basic();
      int cyc;
      sel = 0; set_mem_basic();
      run_pass(-1, 1'b0, cyc);
      tests++;
      if (cap_n !== 3) begin failed++; $display("[TB] FAIL basic_count: got %0d outputs, want 3", cap_n); end
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (cap_data[i] !== 32'd55 || cap_idx[i] !== 2'(i)) begin
            failed++;
            $display("[TB] FAIL basic_out%0d: got idx %0d data %0d, want idx %0d data 55", i, cap_idx[i], $signed(cap_data[i]), i);
         end
      end
      tests++;
      if (cyc !== 20) begin failed++; $display("[TB] FAIL basic_cycles: got %0d, want 20", cyc); end
      tests++;
      if (done_busy !== 0) begin failed++; $display("[TB] FAIL busy_at_done: got %0d, want 0", done_busy); end
      applyStimulus_idle(3);
   endtask

   task automatic test_tail_mask();
      int cyc;
      sel = 0; set_mem_basic();
      for (int k = 10; k < 12; k++) begin
         act_mem[k] = 32'h7FFF_FFFF;
         for (int n = 0; n < 3; n++) w_mem[n][k] = 8'h7F;
      end
      run_pass(-1, 1'b0, cyc);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (cap_data[i] !== 32'd55 || cap_idx[i] !== 2'(i)) begin
            failed++;
            $display("[TB] FAIL tail_out%0d: got idx %0d data %0d, want idx %0d data 55", i, cap_idx[i], $signed(cap_data[i]), i);
         end
      end
      applyStimulus_idle(3);
   endtask

   task automatic test_post_relu_shift();
      int cyc;
      logic [31:0] exp_a [3], exp_b [3], exp_c [3];
      exp_a = '{32'd7, 32'd0, 32'd3};
      exp_b = '{32'd7, 32'hFFFF_FF9C, 32'd3};
      exp_c = '{32'hFFFF_FFFE, 32'd2, 32'd0};
      set_mem_basic();
      for (int k = 0; k < 12; k++) for (int n = 0; n < 3; n++) w_mem[n][k] = 8'd0;
      bias_mem[0] = 32'd7; bias_mem[1] = -32'sd100; bias_mem[2] = 32'd3;
      sel = 0; run_pass(-1, 1'b0, cyc);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (cap_data[i] !== exp_a[i]) begin failed++; $display("[TB] FAIL relu_out%0d: got %0d, want %0d", i, $signed(cap_data[i]), $signed(exp_a[i])); end
      end
      applyStimulus_idle(3);
      sel = 1; run_pass(-1, 1'b0, cyc);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (cap_data[i] !== exp_b[i]) begin failed++; $display("[TB] FAIL norelu_out%0d: got %0d, want %0d", i, $signed(cap_data[i]), $signed(exp_b[i])); end
      end
      applyStimulus_idle(3);
      bias_mem[0] = -32'sd5; bias_mem[1] = 32'd9; bias_mem[2] = 32'd0;
      sel = 2; run_pass(-1, 1'b0, cyc);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (cap_data[i] !== exp_c[i]) begin failed++; $display("[TB] FAIL shift_out%0d: got %0d, want %0d", i, $signed(cap_data[i]), $signed(exp_c[i])); end
      end
      applyStimulus_idle(3);
   endtask

   task automatic test_saturation();
      int cyc;
      logic [31:0] exp_a [3], exp_b [3];
      exp_a = '{32'd40000, 32'd0, 32'd32767};
      exp_b = '{32'd32767, 32'hFFFF_8000, 32'd32767};
      set_mem_basic();
      for (int k = 0; k < 12; k++) for (int n = 0; n < 3; n++) w_mem[n][k] = 8'd0;
      bias_mem[0] = 32'd40000; bias_mem[1] = -32'sd40000; bias_mem[2] = 32'd32767;
      sel = 1; run_pass(-1, 1'b0, cyc);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (cap_data[i] !== exp_b[i]) begin failed++; $display("[TB] FAIL sat16_out%0d: got %0d, want %0d", i, $signed(cap_data[i]), $signed(exp_b[i])); end
      end
      applyStimulus_idle(3);
      sel = 0; run_pass(-1, 1'b0, cyc);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (cap_data[i] !== exp_a[i]) begin failed++; $display("[TB] FAIL sat32_out%0d: got %0d, want %0d", i, $signed(cap_data[i]), $signed(exp_a[i])); end
      end
      applyStimulus_idle(3);
   endtask

   task automatic test_signed_weights();
      int cyc;
      logic [31:0] exp_a [3], exp_b [3];
      exp_a = '{32'd90, 32'd0, 32'd0};
      exp_b = '{32'd90, 32'hFFFF_FFDD, 32'hFFFF_FFC9};
      set_mem_basic();
      for (int k = 0; k < 10; k++) begin w_mem[0][k] = 8'hFE; w_mem[1][k] = 8'd3; w_mem[2][k] = 8'hFF; end
      bias_mem[0] = 32'd200; bias_mem[1] = -32'sd200; bias_mem[2] = 32'd0;
      sel = 0; run_pass(-1, 1'b0, cyc);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (cap_data[i] !== exp_a[i]) begin failed++; $display("[TB] FAIL signed_relu_out%0d: got %0d, want %0d", i, $signed(cap_data[i]), $signed(exp_a[i])); end
      end
      applyStimulus_idle(3);
      sel = 1; run_pass(-1, 1'b0, cyc);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (cap_data[i] !== exp_b[i]) begin failed++; $display("[TB] FAIL signed_out%0d: got %0d, want %0d", i, $signed(cap_data[i]), $signed(exp_b[i])); end
      end
      applyStimulus_idle(3);
   endtask

   task automatic test_back_to_back();
      int cyc, extra;
      sel = 0; set_mem_basic();
      run_pass(1, 1'b1, cyc);
      tests++;
      if (cyc !== 25) begin failed++; $display("[TB] FAIL stall_cycles: got %0d, want 25", cyc); end
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (cap_data[i] !== 32'd55 || cap_idx[i] !== 2'(i)) begin
            failed++;
            $display("[TB] FAIL stall_out%0d: got idx %0d data %0d, want idx %0d data 55", i, cap_idx[i], $signed(cap_data[i]), i);
         end
      end
      extra = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (m_busy || m_valid || a_rd_en) extra++;
      end
      tests++;
      if (extra !== 0) begin failed++; $display("[TB] FAIL held_start_retrigger: got %0d active cycles, want 0", extra); end
      start = 1'b0;
      applyStimulus_idle(3);
   endtask

   task automatic test_reset_mid_pass();
      int cyc, seen_done, seen_valid;
      sel = 0; set_mem_basic();
      @(posedge clk); #1;
      start = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         if (k == 2) start = 1'b0;
      end
      tests++;
      if (a_rd_en !== 1'b1 || a_act_addr !== 2'd2 || a_busy !== 1'b1) begin
         failed++;
         $display("[TB] FAIL mid_pass_position: got rd_en=%b act_addr=%0d busy=%b, want 1 2 1", a_rd_en, a_act_addr, a_busy);
      end
      reset = 1'b1;
      #1;
      tests++;
      if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
         failed++;
         $display("[TB] FAIL reset_abort: got valid=%b busy=%b done=%b, want 0 0 0", a_out_valid, a_busy, a_done);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      seen_done = 0; seen_valid = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (a_done) seen_done++;
         if (a_out_valid) seen_valid++;
      end
      tests++;
      if (seen_done !== 0 || seen_valid !== 0) begin
         failed++;
         $display("[TB] FAIL after_abort_quiet: got done=%0d valid=%0d, want 0 0", seen_done, seen_valid);
      end
      run_pass(-1, 1'b0, cyc);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (cap_data[i] !== 32'd55 || cap_idx[i] !== 2'(i)) begin
            failed++;
            $display("[TB] FAIL rerun_out%0d: got idx %0d data %0d, want idx %0d data 55", i, cap_idx[i], $signed(cap_data[i]), i);
         end
      end
      tests++;
      if (cyc !== 20) begin failed++; $display("[TB] FAIL rerun_cycles: got %0d, want 20", cyc); end
      applyStimulus_idle(3);
   endtask

   initial begin
      set_mem_basic();
      test_reset();
      test_basic();
      test_tail_mask();
      test_post_relu_shift();
      test_saturation();
      test_signed_weights();
      test_back_to_back();
      test_reset_mid_pass();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
